// File: rtl/tmr_add_seq.sv
// Nibble-serial wide adder built on a triple-redundant 4-bit voted adder.
// Carry is chained between nibbles; voter disagreement retries the same nibble up to MAX_RETRY times.

module sum4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [4:0] o_sum
);
    assign o_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_c};
endmodule

module cmp_err_3 (
    input  logic [4:0] i_l1,
    input  logic [4:0] i_l2,
    input  logic [4:0] i_l3,
    output logic       o_err
);
    // An error is flagged only when no two lanes agree; a single bad lane is outvoted.
    assign o_err = (i_l1 != i_l2) && (i_l1 != i_l3) && (i_l2 != i_l3);
endmodule

module tmr_add_seq #(
    parameter int NIBBLES   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   c_in,
    input  logic [3:0]             interference_1,
    input  logic [3:0]             interference_3,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic                   fail,
    output logic [7:0]             err_cnt
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [RTY_W-1:0] r_rty;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_fail;
    logic             r_done;
    logic             r_busy;
    logic [7:0]       r_err_cnt;

    state_t           w_state_nxt;
    logic [W-1:0]     w_a_nxt;
    logic [W-1:0]     w_b_nxt;
    logic             w_carry_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [RTY_W-1:0] w_rty_nxt;
    logic [W-1:0]     w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_fail_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic [7:0]       w_err_cnt_nxt;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [4:0]       w_raw1;
    logic [4:0]       w_raw2;
    logic [4:0]       w_raw3;
    logic [4:0]       w_l1;
    logic [4:0]       w_l2;
    logic [4:0]       w_l3;
    logic [4:0]       w_voted;
    logic             w_err;

    // Word-level majority: lane 1 wins if it matches either other lane, otherwise lane 2.
    function automatic logic [4:0] vote5(input logic [4:0] l1, input logic [4:0] l2,
                                         input logic [4:0] l3);
        logic [4:0] v;
        if ((l1 == l2) || (l1 == l3)) begin
            v = l1;
        end else begin
            v = l2;
        end
        return v;
    endfunction

    assign w_nib_a = r_a[4*r_idx +: 4];
    assign w_nib_b = r_b[4*r_idx +: 4];

    sum4 u_lane1 (.i_a(w_nib_a), .i_b(w_nib_b), .i_c(r_carry), .o_sum(w_raw1));
    sum4 u_lane2 (.i_a(w_nib_a), .i_b(w_nib_b), .i_c(r_carry), .o_sum(w_raw2));
    sum4 u_lane3 (.i_a(w_nib_a), .i_b(w_nib_b), .i_c(r_carry), .o_sum(w_raw3));

    // Fault injection corrupts only the sum bits of lanes 1 and 3, never the carry.
    assign w_l1 = {w_raw1[4], w_raw1[3:0] | interference_1};
    assign w_l2 = w_raw2;
    assign w_l3 = {w_raw3[4], w_raw3[3:0] | interference_3};

    cmp_err_3 u_cmp (.i_l1(w_l1), .i_l2(w_l2), .i_l3(w_l3), .o_err(w_err));

    assign w_voted = vote5(w_l1, w_l2, w_l3);

    // Next-state and datapath update for the IDLE/CALC controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_carry_nxt   = r_carry;
        w_idx_nxt     = r_idx;
        w_rty_nxt     = r_rty;
        w_sum_nxt     = r_sum;
        w_cout_nxt    = r_cout;
        w_fail_nxt    = r_fail;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = r_busy;
        w_err_cnt_nxt = r_err_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_carry_nxt = c_in;
                    w_sum_nxt   = {W{1'b0}};
                    w_cout_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_rty_nxt   = {RTY_W{1'b0}};
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CALC;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_CALC: begin
                if (!w_err) begin
                    w_sum_nxt[4*r_idx +: 4] = w_voted[3:0];
                    w_carry_nxt = w_voted[4];
                    w_rty_nxt   = {RTY_W{1'b0}};
                    if (r_idx == IDX_W'(NIBBLES - 1)) begin
                        w_cout_nxt  = w_voted[4];
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? 8'hFF : (r_err_cnt + 8'd1);
                    if (r_rty == RTY_W'(MAX_RETRY)) begin
                        w_sum_nxt   = {W{1'b0}};
                        w_cout_nxt  = 1'b0;
                        w_fail_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rty_nxt   = r_rty + {{(RTY_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= {W{1'b0}};
            r_b       <= {W{1'b0}};
            r_carry   <= 1'b0;
            r_idx     <= {IDX_W{1'b0}};
            r_rty     <= {RTY_W{1'b0}};
            r_sum     <= {W{1'b0}};
            r_cout    <= 1'b0;
            r_fail    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_carry   <= w_carry_nxt;
            r_idx     <= w_idx_nxt;
            r_rty     <= w_rty_nxt;
            r_sum     <= w_sum_nxt;
            r_cout    <= w_cout_nxt;
            r_fail    <= w_fail_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;
    assign c_out   = r_cout;
    assign fail    = r_fail;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_tmr_add_seq.sv
// Scoreboard bench for tmr_add_seq: expected results are queued at start and compared at done.

module tb_tmr_add_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        c_in = 1'b0;
    logic [3:0]  interference_1 = 4'h0;
    logic [3:0]  interference_3 = 4'h0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        fail;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_err = 8'd0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        fail;
        logic [7:0]  err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    tmr_add_seq #(.NIBBLES(4), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .interference_1(interference_1), .interference_3(interference_3),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .fail(fail),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                                   input logic f, input int lat, input logic [7:0] err);
        exp_t m;
        logic [16:0] t;
        t = {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
        m.sum  = f ? 16'h0000 : t[15:0];
        m.cout = f ? 1'b0 : t[16];
        m.fail = f;
        m.err  = err;
        m.lat  = lat;
        return m;
    endfunction

    // Starts one operation and observes it until done (or the cycle budget runs out).
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          input logic [3:0] m1, input logic [3:0] m3, input int mask_cyc,
                          input int pulse_at, output int lat, output int busy_cnt,
                          output logic busy_end, output logic [15:0] s0, output logic f0,
                          output logic d0);
        @(negedge clk);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s0 = sum; f0 = fail; d0 = done;
        busy_cnt = busy ? 1 : 0;
        busy_end = 1'b1;
        lat = 0;
        if (mask_cyc > 0) begin
            interference_1 = m1; interference_3 = m3;
        end
        for (int k = 1; k <= 40; k++) begin
            if (k - 1 == pulse_at) begin
                a = ~ia; b = ~ib; c_in = ~ic; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k >= mask_cyc) begin
                interference_1 = 4'h0; interference_3 = 4'h0;
            end
            if (done) begin
                lat = k;
                busy_end = busy;
                interference_1 = 4'h0; interference_3 = 4'h0;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 8'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, sum, c_out, fail, err_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h c_out=%b fail=%b err_cnt=%0d, expected all zero",
                     busy, done, sum, c_out, fail, err_cnt);
        end
    endtask

    task automatic test_basic_add();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        sb.push_back(model(16'h1234, 16'h0FCD, 1'b0, 1'b0, 4, exp_err));
        run_op(16'h1234, 16'h0FCD, 1'b0, 4'h0, 4'h0, 0, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, fail, err_cnt} !== {e.sum, e.cout, e.fail, e.err} || sum !== 16'h2201) begin
            errors++;
            $display("FAIL basic_result: got sum=%h c_out=%b fail=%b err=%0d, expected sum=%h c_out=%b fail=%b err=%0d",
                     sum, c_out, fail, err_cnt, e.sum, e.cout, e.fail, e.err);
        end
        checks++;
        if (lat !== e.lat || bc !== e.lat || be !== 1'b0) begin
            errors++;
            $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d busy_at_done=%b, expected %0d/%0d/0",
                     lat, bc, be, e.lat, e.lat);
        end
    endtask

    task automatic test_carry_chain();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        sb.push_back(model(16'hFFFF, 16'h0000, 1'b1, 1'b0, 4, exp_err));
        run_op(16'hFFFF, 16'h0000, 1'b1, 4'h0, 4'h0, 0, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, fail, err_cnt} !== {e.sum, e.cout, e.fail, e.err} || lat !== e.lat) begin
            errors++;
            $display("FAIL carry_chain: got sum=%h c_out=%b lat=%0d, expected sum=%h c_out=%b lat=%0d",
                     sum, c_out, lat, e.sum, e.cout, e.lat);
        end
    endtask

    task automatic test_masked_fault();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        sb.push_back(model(16'h1234, 16'h0FCD, 1'b0, 1'b0, 4, exp_err));
        run_op(16'h1234, 16'h0FCD, 1'b0, 4'hF, 4'h0, 99, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, fail, err_cnt} !== {e.sum, e.cout, e.fail, e.err} || lat !== e.lat) begin
            errors++;
            $display("FAIL masked_fault: got sum=%h fail=%b err=%0d lat=%0d, expected sum=%h fail=%b err=%0d lat=%0d",
                     sum, fail, err_cnt, lat, e.sum, e.fail, e.err, e.lat);
        end
    endtask

    task automatic test_transient();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        exp_err = exp_err + 8'd1;
        sb.push_back(model(16'h0000, 16'h0000, 1'b0, 1'b0, 5, exp_err));
        run_op(16'h0000, 16'h0000, 1'b0, 4'hF, 4'h1, 1, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, fail, err_cnt} !== {e.sum, e.cout, e.fail, e.err}) begin
            errors++;
            $display("FAIL transient_result: got sum=%h fail=%b err=%0d, expected sum=%h fail=%b err=%0d",
                     sum, fail, err_cnt, e.sum, e.fail, e.err);
        end
        checks++;
        if (lat !== e.lat || bc !== e.lat) begin
            errors++;
            $display("FAIL transient_timing: got latency=%0d busy_cycles=%0d, expected %0d", lat, bc, e.lat);
        end
    endtask

    task automatic test_persistent();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        do_reset();
        exp_err = exp_err + 8'd4;
        sb.push_back(model(16'h0000, 16'h0000, 1'b0, 1'b1, 4, exp_err));
        run_op(16'h0000, 16'h0000, 1'b0, 4'hF, 4'h1, 99, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, fail, err_cnt} !== {e.sum, e.cout, e.fail, e.err} || lat !== e.lat) begin
            errors++;
            $display("FAIL persistent_fail: got sum=%h c_out=%b fail=%b err=%0d lat=%0d, expected sum=%h c_out=%b fail=%b err=%0d lat=%0d",
                     sum, c_out, fail, err_cnt, lat, e.sum, e.cout, e.fail, e.err, e.lat);
        end
        sb.push_back(model(16'h8421, 16'h7BDF, 1'b1, 1'b0, 4, exp_err));
        run_op(16'h8421, 16'h7BDF, 1'b1, 4'h0, 4'h0, 0, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if (f0 !== 1'b0 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL fail_clear_on_start: got fail=%b done=%b after accepting edge, expected 0/0", f0, d0);
        end
        checks++;
        if ({sum, c_out, fail, err_cnt} !== {e.sum, e.cout, e.fail, e.err} || lat !== e.lat) begin
            errors++;
            $display("FAIL recovery_add: got sum=%h c_out=%b fail=%b err=%0d lat=%0d, expected sum=%h c_out=%b fail=%b err=%0d lat=%0d",
                     sum, c_out, fail, err_cnt, lat, e.sum, e.cout, e.fail, e.err, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        sb.push_back(model(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 4, exp_err));
        run_op(16'hA5A5, 16'h5A5B, 1'b0, 4'h0, 4'h0, 0, -1, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if (s0 !== 16'h0000 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got sum=%h done=%b after start in done cycle, expected 0000/0", s0, d0);
        end
        checks++;
        if ({sum, c_out, err_cnt} !== {e.sum, e.cout, e.err} || lat !== e.lat) begin
            errors++;
            $display("FAIL b2b_result: got sum=%h c_out=%b lat=%0d, expected sum=%h c_out=%b lat=%0d",
                     sum, c_out, lat, e.sum, e.cout, e.lat);
        end
    endtask

    task automatic test_busy_restart();
        exp_t e; int lat; int bc; logic be; logic [15:0] s0; logic f0; logic d0;
        sb.push_back(model(16'h3C3C, 16'h1111, 1'b1, 1'b0, 4, exp_err));
        run_op(16'h3C3C, 16'h1111, 1'b1, 4'h0, 4'h0, 0, 2, lat, bc, be, s0, f0, d0);
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, err_cnt} !== {e.sum, e.cout, e.err} || lat !== e.lat) begin
            errors++;
            $display("FAIL start_while_busy: got sum=%h c_out=%b lat=%0d, expected sum=%h c_out=%b lat=%0d",
                     sum, c_out, lat, e.sum, e.cout, e.lat);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got busy=%b done=%b cycle after done, expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        a = 16'h7777; b = 16'h8888; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 8'd0;
        checks++;
        if ({busy, done, sum, c_out, fail, err_cnt} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, exp_err}) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b sum=%h c_out=%b fail=%b err_cnt=%0d, expected all zero",
                     busy, done, sum, c_out, fail, err_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d cycles with done/busy after abort, expected 0", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_masked_fault();
        test_transient();
        test_persistent();
        test_back_to_back();
        test_busy_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
